// File: rtl/gardner_lock_ctrl.sv
// Lock detector and gain scheduler for a Gardner timing-recovery loop.
// It averages |er| over fixed windows of symbols. In acquisition it waits
// for enough consecutive quiet windows before declaring lock. In tracking
// it waits for enough consecutive noisy windows before declaring loss of
// lock. When acquisition takes too long, the loop filter is cleared and
// acquisition starts again.
module gardner_lock_ctrl #(
   parameter int unsigned WIN_LOG2    = 6,
   parameter logic [15:0] LOCK_THR    = 16'd512,
   parameter logic [15:0] UNLOCK_THR  = 16'd2048,
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned UNLOCK_CNT  = 3,
   parameter int unsigned TIMEOUT_WIN = 32,
   parameter logic [3:0]  ACQ_SHIFT   = 4'd5,
   parameter logic [3:0]  TRK_SHIFT   = 4'd7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sym_valid,
   input  logic signed [15:0] er,
   output logic [3:0]         gain_shift,
   output logic               loop_clr,
   output logic               locked,
   output logic [1:0]         state,
   output logic [15:0]        err_mag
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      ACQ   = 2'd2,
      TRACK = 2'd3
   } state_t;

   localparam int unsigned ACC_W = 16 + WIN_LOG2;
   localparam int unsigned CNT_W = 16;

   localparam logic [WIN_LOG2-1:0] SYM_ONE     = 1;
   localparam logic [CNT_W-1:0]    CNT_ONE     = 1;
   localparam logic [CNT_W-1:0]    LOCK_LIM    = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]    UNLOCK_LIM  = CNT_W'(UNLOCK_CNT);
   localparam logic [CNT_W-1:0]    TIMEOUT_LIM = CNT_W'(TIMEOUT_WIN);

   state_t              cur, nxt;
   logic [ACC_W-1:0]    acc, accNxt, accSum;
   logic [WIN_LOG2-1:0] symCnt, symNxt;
   logic [CNT_W-1:0]    goodCnt, goodNxt, goodInc;
   logic [CNT_W-1:0]    badCnt, badNxt, badInc;
   logic [CNT_W-1:0]    winCnt, winNxt, winInc;
   logic [15:0]         errNxt;
   logic [15:0]         erRaw, erMag, avg;
   logic                winClose, isGood, isBad;

   // Compute the per-sample magnitude with saturation, and the running window
   // sum and average. Only the most negative input needs the saturation: its
   // two's-complement negation does not fit in 16 bits.
   always_comb begin
      erRaw    = er;
      erMag    = (erRaw == 16'h8000) ? 16'h7FFF : (erRaw[15] ? (~erRaw + 16'd1) : erRaw);
      accSum   = acc + {{WIN_LOG2{1'b0}}, erMag};
      avg      = accSum[ACC_W-1:WIN_LOG2];
      winClose = sym_valid && (symCnt == '1);
      isGood   = avg < LOCK_THR;
      isBad    = avg > UNLOCK_THR;
      goodInc  = goodCnt + CNT_ONE;
      badInc   = badCnt + CNT_ONE;
      winInc   = winCnt + CNT_ONE;
   end

   // Compute the next state, the window accumulator, the window-quality
   // counters and the reported error. en low overrides everything, including
   // a window that closes on the same cycle.
   always_comb begin
      nxt     = cur;
      accNxt  = acc;
      symNxt  = symCnt;
      goodNxt = goodCnt;
      badNxt  = badCnt;
      winNxt  = winCnt;
      errNxt  = err_mag;
      if (!en) begin
         nxt     = IDLE;
         accNxt  = '0;
         symNxt  = '0;
         goodNxt = '0;
         badNxt  = '0;
         winNxt  = '0;
      end else begin
         case (cur)
            IDLE, CLEAR: begin
               nxt     = (cur == IDLE) ? CLEAR : ACQ;
               accNxt  = '0;
               symNxt  = '0;
               goodNxt = '0;
               badNxt  = '0;
               winNxt  = '0;
            end
            ACQ: begin
               if (winClose) begin
                  accNxt  = '0;
                  symNxt  = '0;
                  errNxt  = avg;
                  winNxt  = winInc;
                  goodNxt = isGood ? goodInc : '0;
                  if (isGood && (goodInc == LOCK_LIM)) begin
                     nxt     = TRACK;
                     goodNxt = '0;
                     badNxt  = '0;
                     winNxt  = '0;
                  end else if (winInc == TIMEOUT_LIM) begin
                     nxt     = CLEAR;
                     goodNxt = '0;
                     badNxt  = '0;
                     winNxt  = '0;
                  end
               end else if (sym_valid) begin
                  accNxt = accSum;
                  symNxt = symCnt + SYM_ONE;
               end
            end
            TRACK: begin
               if (winClose) begin
                  accNxt = '0;
                  symNxt = '0;
                  errNxt = avg;
                  badNxt = isBad ? badInc : '0;
                  if (isBad && (badInc == UNLOCK_LIM)) begin
                     nxt     = CLEAR;
                     goodNxt = '0;
                     badNxt  = '0;
                     winNxt  = '0;
                  end
               end else if (sym_valid) begin
                  accNxt = accSum;
                  symNxt = symCnt + SYM_ONE;
               end
            end
            default: begin
               nxt = IDLE;
            end
         endcase
      end
   end

   // Hold the state and all counters in registers. The outputs are decoded
   // from the next state, so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur        <= IDLE;
         acc        <= '0;
         symCnt     <= '0;
         goodCnt    <= '0;
         badCnt     <= '0;
         winCnt     <= '0;
         err_mag    <= '0;
         gain_shift <= ACQ_SHIFT;
         locked     <= 1'b0;
         loop_clr   <= 1'b0;
      end else begin
         cur        <= nxt;
         acc        <= accNxt;
         symCnt     <= symNxt;
         goodCnt    <= goodNxt;
         badCnt     <= badNxt;
         winCnt     <= winNxt;
         err_mag    <= errNxt;
         gain_shift <= (nxt == TRACK) ? TRK_SHIFT : ACQ_SHIFT;
         locked     <= (nxt == TRACK);
         loop_clr   <= (nxt == CLEAR);
      end
   end

   assign state = cur;

endmodule
